// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM request arbiter.
package sram_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE     = 2'd0;
  localparam state_t ACCESS   = 2'd1;
  localparam state_t COMPLETE = 2'd2;

  // Strobe hold counter covers WAIT_CYCLES up to 15.
  localparam int WAIT_CNT_W = 4;

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_request_arbiter_if.sv
// Requester and SRAM-side signals of the arbiter; slave is the arbiter's view.
interface sram_request_arbiter_if #(
  parameter int NUM_PORTS = 5,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
);
  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_write;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        done;
  logic [DATA_W-1:0]           rdata;
  logic                        rdata_valid;
  logic [ADDR_W-1:0]           sram_addr;
  logic [DATA_W-1:0]           sram_wdata;
  logic                        sram_wdata_oe;
  logic [DATA_W-1:0]           sram_rdata;
  logic                        sram_ce_n;
  logic                        sram_we_n;
  logic                        sram_oe_n;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, sram_rdata,
    output done, rdata, rdata_valid, sram_addr, sram_wdata, sram_wdata_oe,
           sram_ce_n, sram_we_n, sram_oe_n
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, sram_rdata,
    input  done, rdata, rdata_valid, sram_addr, sram_wdata, sram_wdata_oe,
           sram_ce_n, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/arb_id_queue.sv
// Circular FIFO of port IDs: several pushes per cycle in ascending index order, one pop.
module arb_id_queue #(
  parameter int NUM_PORTS = 5,
  parameter int ID_W      = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] push,
  input  logic                 pop,
  output logic [ID_W-1:0]      head_id,
  output logic [ID_W:0]        count
);
  localparam int SUM_W = ID_W + 1;

  logic [ID_W-1:0]  mem [NUM_PORTS];
  logic [ID_W-1:0]  head_ptr;
  logic [ID_W-1:0]  tail_ptr;
  logic [ID_W-1:0]  slot [NUM_PORTS];
  logic [SUM_W-1:0] push_cnt;

  function automatic logic [ID_W-1:0] wrap(input logic [SUM_W-1:0] v);
    logic [SUM_W-1:0] r;
    r = (v >= SUM_W'(NUM_PORTS)) ? v - SUM_W'(NUM_PORTS) : v;
    return r[ID_W-1:0];
  endfunction

  // Each pushing port lands after all lower-indexed pushers of the same cycle.
  always_comb begin
    push_cnt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      slot[p] = wrap({1'b0, tail_ptr} + push_cnt);
      if (push[p]) push_cnt = push_cnt + SUM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push[p]) mem[slot[p]] <= ID_W'(p);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      tail_ptr <= wrap({1'b0, tail_ptr} + push_cnt);
      if (pop) head_ptr <= wrap({1'b0, head_ptr} + SUM_W'(1));
      count <= count + push_cnt - SUM_W'(pop);
    end
  end

  assign head_id = mem[head_ptr];

endmodule

// File: rtl/sram_request_arbiter.sv
// First-come-first-served arbiter giving N requesters access to one asynchronous SRAM.
module sram_request_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_PORTS   = 5,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1,
  localparam int ID_W       = id_width(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  sram_request_arbiter_if.slave bus,
  output logic [ID_W:0]        queue_count,
  output logic                 busy
);
  localparam logic [WAIT_CNT_W-1:0] LAST_BEAT = WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t                state;
  logic [WAIT_CNT_W-1:0] beat;
  logic [ID_W-1:0]       cur_id;
  logic [ID_W-1:0]       head_id;
  logic                  cur_write;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [NUM_PORTS-1:0]  pending;
  logic [NUM_PORTS-1:0]  push;
  logic [NUM_PORTS-1:0]  clear;
  logic                  pop;
  logic                  in_access;

  // A port re-enters the queue only once its previous access has fully completed.
  assign push  = bus.req_valid & ~pending;
  assign pop   = (state == IDLE) && run && (queue_count != '0);
  assign clear = (state == COMPLETE) ? (NUM_PORTS'(1) << cur_id) : '0;

  arb_id_queue #(
    .NUM_PORTS (NUM_PORTS),
    .ID_W      (ID_W)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .head_id (head_id),
    .count   (queue_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      beat      <= '0;
      cur_id    <= '0;
      cur_write <= 1'b0;
      addr_q    <= '1;
      wdata_q   <= '0;
      rdata_q   <= '0;
      pending   <= '0;
    end else begin
      pending <= (pending | push) & ~clear;
      case (state)
        IDLE: begin
          if (pop) begin
            state     <= ACCESS;
            beat      <= '0;
            cur_id    <= head_id;
            cur_write <= bus.req_write[head_id];
            addr_q    <= bus.req_addr[int'(head_id)*ADDR_W +: ADDR_W];
            if (bus.req_write[head_id])
              wdata_q <= bus.req_wdata[int'(head_id)*DATA_W +: DATA_W];
          end
        end
        ACCESS: begin
          if (beat == LAST_BEAT) begin
            state <= COMPLETE;
            if (!cur_write) rdata_q <= bus.sram_rdata;
          end else begin
            beat <= beat + WAIT_CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_access         = (state == ACCESS);
  assign busy              = (state != IDLE);
  assign bus.sram_ce_n     = !in_access;
  assign bus.sram_we_n     = !(in_access && cur_write);
  assign bus.sram_oe_n     = !(in_access && !cur_write);
  assign bus.sram_wdata_oe = in_access && cur_write;
  assign bus.sram_addr     = addr_q;
  assign bus.sram_wdata    = wdata_q;
  assign bus.rdata         = rdata_q;
  assign bus.done          = clear;
  assign bus.rdata_valid   = (state == COMPLETE) && !cur_write;

endmodule

// File: tb/tb_sram_request_arbiter.sv
// Directed bench: per-cycle vector table on a WAIT=1 arbiter, hand sequences on a WAIT=3 one.
module tb_sram_request_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run1 = 1'b0;
  logic       run3 = 1'b0;
  logic [3:0] qc1, qc3;
  logic       busy1, busy3;
  int         passed = 0;
  int         total = 0;

  sram_request_arbiter_if #(.NUM_PORTS(5), .ADDR_W(16), .DATA_W(16)) if1 ();
  sram_request_arbiter_if #(.NUM_PORTS(5), .ADDR_W(16), .DATA_W(16)) if3 ();

  sram_request_arbiter #(.NUM_PORTS(5), .ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .run(run1), .bus(if1), .queue_count(qc1), .busy(busy1)
  );

  sram_request_arbiter #(.NUM_PORTS(5), .ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .run(run3), .bus(if3), .queue_count(qc3), .busy(busy3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic [4:0]  valid;
    logic [4:0]  done;
    logic        rv;
    logic [15:0] rdata;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic [15:0] addr;
    logic [3:0]  qc;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [4:0] vl, input logic [4:0] d,
                              input logic rv, input logic [15:0] rd, input logic ce,
                              input logic oe, input logic we, input logic [15:0] a,
                              input logic [3:0] q, input logic b);
    vec_t x;
    x.run = r; x.valid = vl; x.done = d; x.rv = rv; x.rdata = rd;
    x.ce_n = ce; x.oe_n = oe; x.we_n = we; x.addr = a; x.qc = q; x.busy = b;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  initial begin
    // Port p sits at address 0x0010 << p; port 0 writes 0x1234.
    if1.req_valid = '0; if1.req_write = '0; if1.sram_rdata = '0;
    if3.req_valid = '0; if3.req_write = '0; if3.sram_rdata = '0;
    for (int p = 0; p < 5; p++) begin
      if1.req_addr[p*16 +: 16]  = 16'h0010 << p;
      if3.req_addr[p*16 +: 16]  = 16'h0010 << p;
      if1.req_wdata[p*16 +: 16] = 16'h1234 + 16'(p);
      if3.req_wdata[p*16 +: 16] = 16'h1234 + 16'(p);
    end

    // Columns: run, valid | done, rdata_valid, rdata, ce_n, oe_n, we_n, sram_addr, queue_count, busy
    // single read of port 2
    vecs.push_back(mk(1, 5'b00100, 5'b00000, 0, 16'h0000, 1, 1, 1, 16'hFFFF, 0, 0));
    vecs.push_back(mk(1, 5'b00100, 5'b00000, 0, 16'h0000, 1, 1, 1, 16'hFFFF, 1, 0));
    vecs.push_back(mk(1, 5'b00100, 5'b00000, 0, 16'h0000, 0, 0, 1, 16'h0040, 0, 1));
    vecs.push_back(mk(1, 5'b00000, 5'b00100, 1, 16'hBEEF, 1, 1, 1, 16'h0040, 0, 1));
    vecs.push_back(mk(1, 5'b00000, 5'b00000, 0, 16'hBEEF, 1, 1, 1, 16'h0040, 0, 0));
    // ports 4 and 1 together: 1 first
    vecs.push_back(mk(1, 5'b10010, 5'b00000, 0, 16'hBEEF, 1, 1, 1, 16'h0040, 0, 0));
    vecs.push_back(mk(1, 5'b10010, 5'b00000, 0, 16'hBEEF, 1, 1, 1, 16'h0040, 2, 0));
    vecs.push_back(mk(1, 5'b10010, 5'b00000, 0, 16'hBEEF, 0, 0, 1, 16'h0020, 1, 1));
    vecs.push_back(mk(1, 5'b10000, 5'b00010, 1, 16'hC007, 1, 1, 1, 16'h0020, 1, 1));
    vecs.push_back(mk(1, 5'b10000, 5'b00000, 0, 16'hC007, 1, 1, 1, 16'h0020, 1, 0));
    vecs.push_back(mk(1, 5'b10000, 5'b00000, 0, 16'hC007, 0, 0, 1, 16'h0100, 0, 1));
    vecs.push_back(mk(1, 5'b00000, 5'b10000, 1, 16'hC00A, 1, 1, 1, 16'h0100, 0, 1));
    vecs.push_back(mk(1, 5'b00000, 5'b00000, 0, 16'hC00A, 1, 1, 1, 16'h0100, 0, 0));
    // run gated off with ports 0, 2, 3 requesting
    vecs.push_back(mk(0, 5'b01101, 5'b00000, 0, 16'hC00A, 1, 1, 1, 16'h0100, 0, 0));
    vecs.push_back(mk(0, 5'b01101, 5'b00000, 0, 16'hC00A, 1, 1, 1, 16'h0100, 3, 0));
    vecs.push_back(mk(1, 5'b01101, 5'b00000, 0, 16'hC00A, 1, 1, 1, 16'h0100, 3, 0));
    vecs.push_back(mk(1, 5'b01101, 5'b00000, 0, 16'hC00A, 0, 0, 1, 16'h0010, 2, 1));
    vecs.push_back(mk(1, 5'b01100, 5'b00001, 1, 16'hC010, 1, 1, 1, 16'h0010, 2, 1));
    vecs.push_back(mk(1, 5'b01100, 5'b00000, 0, 16'hC010, 1, 1, 1, 16'h0010, 2, 0));
    vecs.push_back(mk(1, 5'b01100, 5'b00000, 0, 16'hC010, 0, 0, 1, 16'h0040, 1, 1));
    vecs.push_back(mk(1, 5'b01000, 5'b00100, 1, 16'hC013, 1, 1, 1, 16'h0040, 1, 1));
    vecs.push_back(mk(1, 5'b01000, 5'b00000, 0, 16'hC013, 1, 1, 1, 16'h0040, 1, 0));
    vecs.push_back(mk(1, 5'b01000, 5'b00000, 0, 16'hC013, 0, 0, 1, 16'h0080, 0, 1));
    vecs.push_back(mk(1, 5'b00000, 5'b01000, 1, 16'hC016, 1, 1, 1, 16'h0080, 0, 1));
    // port 3 holds req_valid past done: one re-enqueue, never a duplicate
    vecs.push_back(mk(1, 5'b01000, 5'b00000, 0, 16'hC016, 1, 1, 1, 16'h0080, 0, 0));
    vecs.push_back(mk(1, 5'b01000, 5'b00000, 0, 16'hC016, 1, 1, 1, 16'h0080, 1, 0));
    vecs.push_back(mk(1, 5'b01000, 5'b00000, 0, 16'hC016, 0, 0, 1, 16'h0080, 0, 1));
    vecs.push_back(mk(1, 5'b01000, 5'b01000, 1, 16'hC01A, 1, 1, 1, 16'h0080, 0, 1));
    vecs.push_back(mk(1, 5'b01000, 5'b00000, 0, 16'hC01A, 1, 1, 1, 16'h0080, 0, 0));
    vecs.push_back(mk(1, 5'b01000, 5'b00000, 0, 16'hC01A, 1, 1, 1, 16'h0080, 1, 0));
    vecs.push_back(mk(1, 5'b01000, 5'b00000, 0, 16'hC01A, 0, 0, 1, 16'h0080, 0, 1));
    vecs.push_back(mk(1, 5'b00000, 5'b01000, 1, 16'hC01E, 1, 1, 1, 16'h0080, 0, 1));
    vecs.push_back(mk(1, 5'b00000, 5'b00000, 0, 16'hC01E, 1, 1, 1, 16'h0080, 0, 0));

    // Reset state
    repeat (2) @(negedge clk);
    check("reset done",     32'(if1.done), 32'h0);
    check("reset rvalid",   32'(if1.rdata_valid), 32'h0);
    check("reset rdata",    32'(if1.rdata), 32'h0);
    check("reset strobes",  32'({if1.sram_ce_n, if1.sram_we_n, if1.sram_oe_n}), 32'h7);
    check("reset wdata_oe", 32'(if1.sram_wdata_oe), 32'h0);
    check("reset addr",     32'(if1.sram_addr), 32'hFFFF);
    check("reset wdata",    32'(if1.sram_wdata), 32'h0);
    check("reset qcount",   32'(qc1), 32'h0);
    check("reset busy",     32'(busy1), 32'h0);
    reset = 1'b1;

    // SRAM read data differs every vector so each capture edge is pinned down.
    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("v%0d done", i),     32'(if1.done), 32'(vecs[i].done));
      check($sformatf("v%0d rvalid", i),   32'(if1.rdata_valid), 32'(vecs[i].rv));
      check($sformatf("v%0d rdata", i),    32'(if1.rdata), 32'(vecs[i].rdata));
      check($sformatf("v%0d strobes", i),  32'({if1.sram_ce_n, if1.sram_oe_n, if1.sram_we_n}),
            32'({vecs[i].ce_n, vecs[i].oe_n, vecs[i].we_n}));
      check($sformatf("v%0d wdata_oe", i), 32'(if1.sram_wdata_oe), 32'(!vecs[i].we_n));
      check($sformatf("v%0d addr", i),     32'(if1.sram_addr), 32'(vecs[i].addr));
      check($sformatf("v%0d qcount", i),   32'(qc1), 32'(vecs[i].qc));
      check($sformatf("v%0d busy", i),     32'(busy1), 32'(vecs[i].busy));
      run1 = vecs[i].run;
      if1.req_valid = vecs[i].valid;
      if1.sram_rdata = (i == 2) ? 16'hBEEF : 16'hC000 + 16'(i);
      @(negedge clk);
    end

    // WAIT=3 write from port 0: strobe held exactly three cycles, done at cycle 5
    run3 = 1'b1;
    if3.req_write = 5'b00001;
    if3.req_valid = 5'b00001;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("wr c%0d we_n", c),     32'(if3.sram_we_n), 32'(!(c >= 2 && c <= 4)));
      check($sformatf("wr c%0d wdata_oe", c), 32'(if3.sram_wdata_oe), 32'(c >= 2 && c <= 4));
      check($sformatf("wr c%0d oe_n", c),     32'(if3.sram_oe_n), 32'h1);
      check($sformatf("wr c%0d done", c),     32'(if3.done), (c == 5) ? 32'h1 : 32'h0);
      check($sformatf("wr c%0d rvalid", c),   32'(if3.rdata_valid), 32'h0);
      if (c >= 2 && c <= 4) begin
        check($sformatf("wr c%0d wdata", c), 32'(if3.sram_wdata), 32'h1234);
        check($sformatf("wr c%0d addr", c),  32'(if3.sram_addr), 32'h0010);
      end
      if (c == 5) if3.req_valid = 5'b00000;
    end

    // Reset asserted mid-write with port 1 queued behind it
    if3.req_valid = 5'b00001;
    @(negedge clk);
    if3.req_valid = 5'b00011;
    @(negedge clk);
    check("mid we_n before reset", 32'(if3.sram_we_n), 32'h0);
    check("mid qcount before reset", 32'(qc3), 32'h1);
    reset = 1'b0;
    #1;
    check("abort strobes",  32'({if3.sram_ce_n, if3.sram_we_n, if3.sram_oe_n}), 32'h7);
    check("abort wdata_oe", 32'(if3.sram_wdata_oe), 32'h0);
    check("abort qcount",   32'(qc3), 32'h0);
    check("abort busy",     32'(busy3), 32'h0);
    @(negedge clk);
    if3.req_valid = 5'b00000;
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("post c%0d done", c), 32'(if3.done), 32'h0);
      check($sformatf("post c%0d ce_n", c), 32'(if3.sram_ce_n), 32'h1);
    end
    check("post qcount", 32'(qc3), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_request_arbiter.md
Name: sram_request_arbiter

Overview:
- Parametrised successor of the team's 5-requester SRAM I/O handler: N requester ports share one asynchronous SRAM through a first-come-first-served queue of port IDs.
- Adds an explicit valid/done handshake, configurable SRAM strobe width, a run gate, and a registered read-data return.
- Sits between the CPU cluster and the board SRAM tristate driver.

Parameters:
- NUM_PORTS, 5, number of requester ports (2..8).
- ADDR_W, 16, SRAM address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 1, clock cycles each SRAM strobe is held low (1..15).
- ID_W, $clog2(NUM_PORTS), port-ID width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  arbiter may start new accesses while high.
- req_valid  in  NUM_PORTS  per-port request; held high until that port's done.
- req_write  in  NUM_PORTS  per-port: 1=write, 0=read; stable while req_valid.
- req_addr  in  NUM_PORTS*ADDR_W  packed per-port address; port p at [p*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*DATA_W  packed per-port write data.
- done  out  NUM_PORTS  one-cycle completion pulse, one-hot.
- rdata  out  DATA_W  read data, valid while rdata_valid is high.
- rdata_valid  out  1  one-cycle pulse with done for reads only.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  data to tristate.
- sram_wdata_oe  out  1  tristate drive enable.
- sram_rdata  in  DATA_W  data from tristate.
- sram_ce_n, sram_we_n, sram_oe_n  out  1 each  active-low SRAM controls.
- queue_count  out  ID_W+1  number of queued (not yet in service) IDs.
- busy  out  1  high when not IDLE.

Behaviour:
- Reset: queue and pending[] cleared; state=IDLE; done=0, rdata_valid=0, rdata=0; sram_ce_n=sram_we_n=sram_oe_n=1; sram_wdata_oe=0; sram_addr=all-ones; sram_wdata=0; queue_count=0. Async assert mid-access aborts immediately; a partial write is accepted.
- Enqueue (every cycle, including while run=0): port p is pushed when req_valid[p]=1 and pending[p]=0, then pending[p] is set. Several ports may push in one cycle; they enter in ascending index order. Each port holds at most one entry, so the queue depth is NUM_PORTS and it never overflows.
- Push and pop in the same cycle: the pop takes the old head; queue_count nets to count+pushes-1.
- FSM IDLE: strobes high. If run=1 and queue non-empty, pop the head and latch id, write, addr and wdata; go to ACCESS. If run=0, stay in IDLE.
- FSM ACCESS (WAIT_CYCLES cycles):
  - sram_ce_n=0; sram_addr=latched addr.
  - Write: sram_we_n=0, sram_wdata_oe=1, sram_wdata=latched data.
  - Read: sram_oe_n=0; rdata captures sram_rdata on the final ACCESS cycle edge.
- FSM COMPLETE (1 cycle): all strobes high, sram_wdata_oe=0; done[id]=1; rdata_valid=1 if read; pending[id] cleared at the edge. Next state is IDLE.
- Latency: from req_valid sampled with an empty queue to the done pulse is WAIT_CYCLES+2 cycles. Per-access occupancy is WAIT_CYCLES+2 cycles.
- Requester rule: drop req_valid in the done cycle. If req_valid is still high on the following cycle, it is a new request and is re-enqueued.
- Dropping req_valid while queued does not remove the entry; the access still executes.
- sram_addr and sram_wdata are held on the last value outside ACCESS; only the strobes deassert. rdata holds its value until the next read.
- Combined flag: busy = (state != IDLE).

Decomposition:
- Package sram_arb_pkg: state enum {IDLE, ACCESS, COMPLETE}, WAIT counter width constant, and an ID-width helper function.
- Sub-module arb_id_queue: circular ID FIFO with multi-push in index order, single pop, and count output. The top level holds the FSM, pending[] and the SRAM drive.

Test Plan:
- Reset, then read port 2 at addr 0x0040 with SRAM returning 0xBEEF, WAIT=1 -> sram_oe_n low for 1 cycle with addr 0x0040; done=5'b00100 and rdata=0xBEEF/rdata_valid at cycle 3.
- Ports 4 and 1 raise req_valid in the same cycle -> service order 1 then 4; done pulses 3 cycles apart; queue_count peaks at 2.
- Port 0 writes 0x1234 to 0x0010 with WAIT=3 -> sram_we_n and sram_wdata_oe low/high for exactly 3 cycles with data 0x1234; done[0] pulses at cycle 5; rdata_valid stays 0.
- run=0 while 3 ports request -> no strobes; queue_count=3; after run=1, the three accesses complete in arrival order.
- Port 3 keeps req_valid high past done -> second access is enqueued and completes; no duplicate entry while pending.
- Assert reset mid-ACCESS write -> strobes high and oe low immediately; queue_count=0; no done pulse after release.
